// File: rtl/dbus_arbiter.sv
// dbus_arbiter
//   Shares the single data-bus port that feeds the bus bridge (DM + TC0/TC1)
//   between two masters. M0 is the CPU M-stage and M1 is the secondary
//   master (loader/DMA). At most one master is granted per cycle. Read data
//   returns one cycle after the grant and is routed back to the master that
//   issued the read. Arbitration is round-robin or fixed priority. M1 can
//   also hold a bounded bus lock for bursts.
//
// Parameters
//   RR_EN     1: round-robin between M0/M1, 0: fixed priority (M0 wins)
//   LOCK_MAX  maximum consecutive M1 grants while m1_lock is held (1..255)
//
// Ports
//   clk, reset                  system clock, synchronous active-high reset
//   mX_req/addr/wdata/byteen    master request; byteen == 4'b0000 is a read
//   mX_gnt                      request accepted this cycle (combinational)
//   mX_rvalid/rdata             read return, one cycle after a read grant
//   m1_lock                     M1 asks to keep the bus for back-to-back beats
//   bus_addr/wdata/byteen       to bridge, all zero on idle cycles
//   bus_rdata                   from bridge, valid the cycle after the address
//
// FSM states
//   state      | meaning
//   ST_ARB     | normal arbitration (round-robin or fixed priority)
//   ST_LOCKED  | M1 burst lock; M1 wins whenever it requests
module dbus_arbiter #(
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,

  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic [31:0] bus_rdata
);

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic SEL_M0 = 1'b0;
  localparam logic SEL_M1 = 1'b1;

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  logic [0:0] state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       yield_q, yield_d;

  logic        gnt0, gnt1;
  logic        m0_rv_q, m1_rv_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;

  // Grant decode: combinational from the requests and the registered state.
  // Nothing is granted while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (state_q == ST_LOCKED) begin
        if (m1_req)      gnt1 = 1'b1;
        else if (m0_req) gnt0 = 1'b1;
      end else if (m0_req && m1_req) begin
        // A forced lock exit leaves yield set, so M0 gets the next contest
        // even under fixed priority.
        if (yield_q || !RR_EN)    gnt0 = 1'b1;
        else if (last_q == SEL_M1) gnt0 = 1'b1;
        else                      gnt1 = 1'b1;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    yield_d    = yield_q;

    if (gnt0) last_d = SEL_M0;
    if (gnt1) last_d = SEL_M1;

    // Yield only matters while M0 is actually waiting.
    if (gnt0 || !m0_req) yield_d = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (gnt1 && m1_lock) begin
          // With LOCK_MAX == 1 the first locked grant already exhausts the
          // budget, so treat it as an immediate forced exit.
          if (LOCK_MAX_C <= 8'd1) begin
            yield_d = 1'b1;
          end else begin
            state_d    = ST_LOCKED;
            lock_cnt_d = 8'd1;
          end
        end
      end
      ST_LOCKED: begin
        if (gnt1) lock_cnt_d = lock_cnt_q + 8'd1;
        if (gnt1 && ((lock_cnt_q + 8'd1) == LOCK_MAX_C)) begin
          state_d    = ST_ARB;
          lock_cnt_d = 8'd0;
          yield_d    = 1'b1;
          last_d     = SEL_M1;
        end else if (!m1_lock) begin
          state_d    = ST_ARB;
          lock_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d    = ST_ARB;
        lock_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_ARB;
      last_q     <= SEL_M1;
      lock_cnt_q <= 8'd0;
      yield_q    <= 1'b0;
      m0_rv_q    <= 1'b0;
      m1_rv_q    <= 1'b0;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      yield_q    <= yield_d;
      // The owner flags double as the read-return valids of the next cycle.
      m0_rv_q    <= gnt0 && (m0_byteen == 4'b0000);
      m1_rv_q    <= gnt1 && (m1_byteen == 4'b0000);
      if (m0_rv_q) m0_rdata_q <= bus_rdata;
      if (m1_rv_q) m1_rdata_q <= bus_rdata;
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // Gating with reset cancels a return that is pending when reset arrives.
  assign m0_rvalid = m0_rv_q & ~reset;
  assign m1_rvalid = m1_rv_q & ~reset;

  // Data goes straight through in the return cycle. The register keeps the
  // last value for the cycles after that.
  assign m0_rdata = m0_rvalid ? bus_rdata : m0_rdata_q;
  assign m1_rdata = m1_rvalid ? bus_rdata : m1_rdata_q;

  always_comb begin
    bus_addr   = 32'd0;
    bus_wdata  = 32'd0;
    bus_byteen = 4'b0000;
    if (gnt0) begin
      bus_addr   = m0_addr;
      bus_wdata  = m0_wdata;
      bus_byteen = m0_byteen;
    end else if (gnt1) begin
      bus_addr   = m1_addr;
      bus_wdata  = m1_wdata;
      bus_byteen = m1_byteen;
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
module tb_dbus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_rdata = 32'd0;

  logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_bus_addr, fp_bus_wdata;
  logic [3:0]  fp_bus_byteen;
  logic [31:0] fp_bus_rdata = 32'd0;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0]  exp_g3  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0]  exp_rv3 [4] = '{2'b00, 2'b01, 2'b10, 2'b01};
  logic [31:0] exp_a3  [4] = '{32'h200, 32'h100, 32'h200, 32'h100};

  always #5 clk = ~clk;

  dbus_arbiter #(.RR_EN(1'b1), .LOCK_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byteen(bus_byteen),
    .bus_rdata(bus_rdata)
  );

  dbus_arbiter #(.RR_EN(1'b0), .LOCK_MAX(8)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
    .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
    .m1_lock(m1_lock), .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
    .bus_addr(fp_bus_addr), .bus_wdata(fp_bus_wdata), .bus_byteen(fp_bus_byteen),
    .bus_rdata(fp_bus_rdata)
  );

  // Synchronous data memory: the word appears the cycle after the address.
  function automatic logic [31:0] dm_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'h1234_5678 : (a ^ 32'hA5A5_0000);
  endfunction

  always @(posedge clk) begin
    bus_rdata    <= dm_word(bus_addr);
    fp_bus_rdata <= dm_word(fp_bus_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_byteen = 4'h0;
    m1_req = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_byteen = 4'h0;
    m1_lock = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_gnt", {30'd0, m0_gnt, m1_gnt}, 32'h0);
      chk("t1_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'h0);
      chk("t1_byteen", {28'd0, bus_byteen}, 32'h0);
      chk("t1_addr", bus_addr, 32'h0);
      chk("t1_wdata", bus_wdata, 32'h0);
      chk("t1_m0_rdata", m0_rdata, 32'h0);
      chk("t1_m1_rdata", m1_rdata, 32'h0);
      tick();
    end

    // 2: single M0 read of 0x10
    m0_req = 1'b1; m0_addr = 32'h10; m0_byteen = 4'h0; m0_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t2_gnt", {30'd0, m0_gnt, m1_gnt}, 32'h2);
    chk("t2_bus_addr", bus_addr, 32'h10);
    chk("t2_bus_byteen", {28'd0, bus_byteen}, 32'h0);
    chk("t2_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    tick();
    m0_req = 1'b0;
    @(negedge clk);
    chk("t2_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'h2);
    chk("t2_rdata", m0_rdata, 32'h1234_5678);
    chk("t2_idle_gnt", {30'd0, m0_gnt, m1_gnt}, 32'h0);
    chk("t2_idle_addr", bus_addr, 32'h0);
    tick();
    @(negedge clk);
    chk("t2_rvalid_off", {30'd0, m0_rvalid, m1_rvalid}, 32'h0);
    chk("t2_rdata_hold", m0_rdata, 32'h1234_5678);
    tick();

    // 3: both masters read every cycle; last grant was M0 so M1 goes first
    m0_req = 1'b1; m0_addr = 32'h100; m0_byteen = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h200; m1_byteen = 4'h0; m1_lock = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_rr_gnt", {30'd0, m0_gnt, m1_gnt}, {30'd0, exp_g3[i]});
      chk("t3_rr_rvalid", {30'd0, m0_rvalid, m1_rvalid}, {30'd0, exp_rv3[i]});
      chk("t3_rr_addr", bus_addr, exp_a3[i]);
      chk("t3_fp_gnt", {30'd0, fp_m0_gnt, fp_m1_gnt}, 32'h2);
      chk("t3_fp_addr", fp_bus_addr, 32'h100);
      if (i == 1) chk("t3_m1_rdata", m1_rdata, 32'hA5A5_0200);
      if (i == 2) chk("t3_m0_rdata", m0_rdata, 32'hA5A5_0100);
      if (i > 0) begin
        chk("t3_fp_m0_rvalid", {31'd0, fp_m0_rvalid}, 32'h1);
        chk("t3_fp_m0_rdata", fp_m0_rdata, 32'hA5A5_0100);
      end
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    chk("t3_tail_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'h2);
    chk("t3_tail_rdata", m0_rdata, 32'hA5A5_0100);
    chk("t3_fp_starved_rv", {31'd0, fp_m1_rvalid}, 32'h0);
    chk("t3_fp_starved_rdata", fp_m1_rdata, 32'h0);
    chk("t3_fp_idle_byteen", {28'd0, fp_bus_byteen}, 32'h0);
    chk("t3_fp_idle_wdata", fp_bus_wdata, 32'h0);
    tick();

    // 4: M1 locked write burst against a waiting M0, LOCK_MAX = 8
    m0_req = 1'b1; m0_addr = 32'h100; m0_byteen = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h7F00; m1_wdata = 32'hCAFE_0001; m1_byteen = 4'hF;
    m1_lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t4_lock_gnt", {30'd0, m0_gnt, m1_gnt}, 32'h1);
      chk("t4_lock_byteen", {28'd0, bus_byteen}, 32'hF);
      chk("t4_lock_addr", bus_addr, 32'h7F00);
      chk("t4_no_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'h0);
      if (i == 0) chk("t4_lock_wdata", bus_wdata, 32'hCAFE_0001);
      tick();
    end
    @(negedge clk);
    chk("t4_exit_gnt", {30'd0, m0_gnt, m1_gnt}, 32'h2);
    chk("t4_exit_byteen", {28'd0, bus_byteen}, 32'h0);
    chk("t4_exit_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'h0);
    tick();
    @(negedge clk);
    chk("t4_reenter_gnt", {30'd0, m0_gnt, m1_gnt}, 32'h1);
    chk("t4_reenter_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'h2);
    chk("t4_reenter_rdata", m0_rdata, 32'hA5A5_0100);
    tick();
    @(negedge clk);
    chk("t4_relocked_gnt", {30'd0, m0_gnt, m1_gnt}, 32'h1);
    tick();
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    @(negedge clk);
    chk("t4_idle_gnt", {30'd0, m0_gnt, m1_gnt}, 32'h0);
    tick();

    // 5: lock held for 3 grants, then released
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 32'h7F04; m1_byteen = 4'hF;
    @(negedge clk);
    chk("t5_g1", {30'd0, m0_gnt, m1_gnt}, 32'h1);
    tick();
    m0_req = 1'b1; m0_addr = 32'h100; m0_byteen = 4'h0;
    @(negedge clk);
    chk("t5_g2", {30'd0, m0_gnt, m1_gnt}, 32'h1);
    tick();
    @(negedge clk);
    chk("t5_g3", {30'd0, m0_gnt, m1_gnt}, 32'h1);
    tick();
    m1_req = 1'b0; m1_lock = 1'b0;
    @(negedge clk);
    chk("t5_release_gnt", {30'd0, m0_gnt, m1_gnt}, 32'h2);
    tick();
    m1_req = 1'b1;
    @(negedge clk);
    chk("t5_arb_m1", {30'd0, m0_gnt, m1_gnt}, 32'h1);
    chk("t5_arb_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'h2);
    tick();
    @(negedge clk);
    chk("t5_arb_m0", {30'd0, m0_gnt, m1_gnt}, 32'h2);
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    // 6: reset lands in the return cycle of an M1 read
    m1_req = 1'b1; m1_addr = 32'h300; m1_byteen = 4'h0; m1_lock = 1'b0;
    @(negedge clk);
    chk("t6_m1_gnt", {30'd0, m0_gnt, m1_gnt}, 32'h1);
    tick();
    reset = 1'b1; m1_req = 1'b0;
    @(negedge clk);
    chk("t6_rv_cancel", {31'd0, m1_rvalid}, 32'h0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rv_after", {30'd0, m0_rvalid, m1_rvalid}, 32'h0);
    chk("t6_m1_rdata_clr", m1_rdata, 32'h0);
    chk("t6_m0_rdata_clr", m0_rdata, 32'h0);
    tick();
    m0_req = 1'b1; m0_addr = 32'h100; m0_byteen = 4'h0;
    m1_req = 1'b1; m1_addr = 32'h300; m1_byteen = 4'h0;
    @(negedge clk);
    chk("t6_first_contest", {30'd0, m0_gnt, m1_gnt}, 32'h2);
    tick();
    @(negedge clk);
    chk("t6_second_contest", {30'd0, m0_gnt, m1_gnt}, 32'h1);
    chk("t6_m0_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'h2);
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
